// File: rtl/fpu_round_pack_if.sv
// rtl/fpu_round_pack_if.sv - beat and handshake signals of the fpu_round_pack pipeline
interface fpu_round_pack_if #(parameter int TAG_W = 5);
   logic             i_valid;
   logic             i_ready;
   logic [TAG_W-1:0] i_tag;
   logic             i_sign;
   logic [10:0]      i_exp;
   logic [24:0]      i_frac;
   logic             i_is_zero;
   logic             i_is_inf;
   logic             i_is_nan;
   logic             i_invalid;
   logic [1:0]       i_rm;
   logic             i_dn;
   logic             o_valid;
   logic             o_ready;
   logic [TAG_W-1:0] o_tag;
   logic [31:0]      o_result;
   logic             o_inexact;
   logic             o_overflow;
   logic             o_underflow;
   logic             o_invalid;

   modport master (
      output i_valid, i_tag, i_sign, i_exp, i_frac, i_is_zero, i_is_inf, i_is_nan,
             i_invalid, i_rm, i_dn, o_ready,
      input  i_ready, o_valid, o_tag, o_result, o_inexact, o_overflow, o_underflow, o_invalid
   );

   modport slave (
      input  i_valid, i_tag, i_sign, i_exp, i_frac, i_is_zero, i_is_inf, i_is_nan,
             i_invalid, i_rm, i_dn, o_ready,
      output i_ready, o_valid, o_tag, o_result, o_inexact, o_overflow, o_underflow, o_invalid
   );
endinterface

// File: rtl/fpu_round_pack.sv
// rtl/fpu_round_pack.sv - FPU round/pack back end, two-stage valid/ready pipeline
// Define FPU_RP_DENORM_EN to produce denormal results instead of flushing tiny ones.
module fpu_round_pack #(
   parameter int TAG_W = 5
) (
   input logic             clk,
   input logic             rst,
   fpu_round_pack_if.slave bus
);

   typedef enum logic [2:0] {K_NUM, K_ZERO, K_INF, K_NAN, K_OVF} kind_t;

   logic adv;
   assign adv         = bus.o_ready || !bus.o_valid;
   assign bus.i_ready = adv;

   logic               rn, g, s, inc_n, tiny, ovf;
   logic [22:0]        mant;
   logic [23:0]        sum_n;
   logic signed [11:0] be, be_r;

   assign mant  = bus.i_frac[24:2];
   assign g     = bus.i_frac[1];
   assign s     = bus.i_frac[0];
   assign rn    = (bus.i_rm != 2'b01);
   assign inc_n = rn & g & (s | mant[0]);
   assign sum_n = {1'b0, mant} + {23'd0, inc_n};
   assign be    = $signed({bus.i_exp[10], bus.i_exp}) + 12'sd127;
   // a mantissa carry-out leaves sum_n[22:0] = 0 and bumps the exponent
   assign be_r  = be + $signed({11'd0, sum_n[23]});
   assign tiny  = (be <= 12'sd0);
   assign ovf   = (be_r >= 12'sd255);

`ifdef FPU_RP_DENORM_EN
   logic [11:0] sh_full;
   logic [4:0]  shamt;
   logic        unused_dn_msb, dn_g, dn_s, dn_inc;
   logic [22:0] dn_f;
   logic [24:0] dn_tail;
   logic [23:0] dn_sum;

   assign sh_full = 12'd1 - $unsigned(be);
   assign shamt   = (sh_full > 12'd26) ? 5'd26 : sh_full[4:0];
   assign {unused_dn_msb, dn_f, dn_g, dn_tail} = {1'b1, mant, g, 25'd0} >> shamt;
   assign dn_s    = (|dn_tail) | s;
   assign dn_inc  = rn & dn_g & (dn_s | dn_f[0]);
   // dn_sum[23] lands in exponent bit 0, giving the smallest normal on carry
   assign dn_sum  = {1'b0, dn_f} + {23'd0, dn_inc};
`else
   logic unused_dn;
   assign unused_dn = bus.i_dn;
`endif

   kind_t       s1_kind_d;
   logic [30:0] s1_mag_d;
   logic        s1_inx_d, s1_uf_d;

   always_comb begin
      s1_kind_d = K_NUM;
      s1_mag_d  = {be_r[7:0], sum_n[22:0]};
      s1_inx_d  = g | s;
      s1_uf_d   = 1'b0;
      if (bus.i_is_nan)
         s1_kind_d = K_NAN;
      else if (bus.i_is_inf)
         s1_kind_d = K_INF;
      else if (bus.i_is_zero)
         s1_kind_d = K_ZERO;
      else if (ovf)
         s1_kind_d = K_OVF;
      else if (tiny) begin
`ifdef FPU_RP_DENORM_EN
         if (!bus.i_dn) begin
            s1_mag_d = {7'd0, dn_sum};
            s1_inx_d = dn_g | dn_s;
            s1_uf_d  = dn_g | dn_s;
         end else begin
            s1_mag_d = 31'd0;
            s1_inx_d = 1'b1;
            s1_uf_d  = 1'b1;
         end
`else
         s1_mag_d = 31'd0;
         s1_inx_d = 1'b1;
         s1_uf_d  = 1'b1;
`endif
      end
   end

   logic             s1_valid, s1_sign, s1_rz, s1_inx, s1_uf, s1_invalid;
   logic [TAG_W-1:0] s1_tag;
   kind_t            s1_kind;
   logic [30:0]      s1_mag;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_tag     <= '0;
         s1_sign    <= 1'b0;
         s1_rz      <= 1'b0;
         s1_kind    <= K_ZERO;
         s1_mag     <= 31'd0;
         s1_inx     <= 1'b0;
         s1_uf      <= 1'b0;
         s1_invalid <= 1'b0;
      end else if (adv) begin
         s1_valid   <= bus.i_valid;
         s1_tag     <= bus.i_tag;
         s1_sign    <= bus.i_sign;
         s1_rz      <= !rn;
         s1_kind    <= s1_kind_d;
         s1_mag     <= s1_mag_d;
         s1_inx     <= s1_inx_d;
         s1_uf      <= s1_uf_d;
         s1_invalid <= bus.i_invalid;
      end
   end

   logic [31:0] res_d;
   logic        inx_d, ovf_d, uf_d;

   always_comb begin
      res_d = {s1_sign, s1_mag};
      inx_d = 1'b0;
      ovf_d = 1'b0;
      uf_d  = 1'b0;
      case (s1_kind)
         K_NAN:  res_d = 32'h7FBFFFFF;
         K_INF:  res_d = {s1_sign, 8'hFF, 23'd0};
         K_ZERO: res_d = {s1_sign, 31'd0};
         K_OVF: begin
            res_d = s1_rz ? {s1_sign, 31'h7F7FFFFF} : {s1_sign, 8'hFF, 23'd0};
            inx_d = 1'b1;
            ovf_d = 1'b1;
         end
         default: begin
            inx_d = s1_inx;
            uf_d  = s1_uf;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.o_valid     <= 1'b0;
         bus.o_tag       <= '0;
         bus.o_result    <= 32'd0;
         bus.o_inexact   <= 1'b0;
         bus.o_overflow  <= 1'b0;
         bus.o_underflow <= 1'b0;
         bus.o_invalid   <= 1'b0;
      end else if (adv) begin
         bus.o_valid     <= s1_valid;
         bus.o_tag       <= s1_tag;
         bus.o_result    <= res_d;
         bus.o_inexact   <= inx_d;
         bus.o_overflow  <= ovf_d;
         bus.o_underflow <= uf_d;
         bus.o_invalid   <= s1_invalid;
      end
   end

endmodule

// File: tb/tb_fpu_round_pack.sv
// tb/tb_fpu_round_pack.sv - directed self-checking bench for fpu_round_pack
module tb_fpu_round_pack;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fpu_round_pack_if #(.TAG_W(5)) bus ();
   fpu_round_pack #(.TAG_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

   // flag nibble order: {inexact, overflow, underflow, invalid}
   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", name, obs, req);
      end
   endtask

   function automatic logic [31:0] flags();
      return {28'd0, bus.o_inexact, bus.o_overflow, bus.o_underflow, bus.o_invalid};
   endfunction

   // spc = {nan, inf, zero}
   task automatic set_beat(input logic [4:0] tag, input logic sign, input logic [10:0] e,
                           input logic [24:0] frac, input logic [2:0] spc, input logic inv,
                           input logic [1:0] rm, input logic dn);
      bus.i_tag     = tag;
      bus.i_sign    = sign;
      bus.i_exp     = e;
      bus.i_frac    = frac;
      bus.i_is_nan  = spc[2];
      bus.i_is_inf  = spc[1];
      bus.i_is_zero = spc[0];
      bus.i_invalid = inv;
      bus.i_rm      = rm;
      bus.i_dn      = dn;
   endtask

   task automatic run_one(input string name, input logic [4:0] tag, input logic sign,
                          input logic [10:0] e, input logic [24:0] frac, input logic [2:0] spc,
                          input logic inv, input logic [1:0] rm, input logic dn,
                          input logic [31:0] req_res, input logic [3:0] req_flags);
      @(negedge clk);
      set_beat(tag, sign, e, frac, spc, inv, rm, dn);
      bus.i_valid = 1'b1;
      check({name, " i_ready"}, {31'd0, bus.i_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.i_valid = 1'b0;
      check({name, " lat1 o_valid"}, {31'd0, bus.o_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check({name, " o_valid"}, {31'd0, bus.o_valid}, 32'd1);
      check({name, " o_tag"}, {27'd0, bus.o_tag}, {27'd0, tag});
      check({name, " o_result"}, bus.o_result, req_res);
      check({name, " flags"}, flags(), {28'd0, req_flags});
   endtask

   initial begin
      rst         = 1'b1;
      bus.i_valid = 1'b0;
      bus.o_ready = 1'b1;
      set_beat(5'd0, 1'b0, 11'd0, 25'd0, 3'b000, 1'b0, 2'b00, 1'b0);
      repeat (2) @(negedge clk);
      check("reset o_valid", {31'd0, bus.o_valid}, 32'd0);
      check("reset o_result", bus.o_result, 32'd0);
      check("reset o_tag", {27'd0, bus.o_tag}, 32'd0);
      check("reset flags", flags(), 32'd0);
      rst = 1'b0;

      run_one("one_rn",      5'd1, 1'b0, 11'd0,    25'd0,         3'b000, 1'b0, 2'b00, 1'b0, 32'h3F800000, 4'b0000);
      run_one("ones_rn",     5'd2, 1'b0, 11'd0,    25'h1FFFFFF,   3'b000, 1'b0, 2'b00, 1'b0, 32'h40000000, 4'b1000);
      run_one("ones_rz",     5'd3, 1'b0, 11'd0,    25'h1FFFFFF,   3'b000, 1'b0, 2'b01, 1'b0, 32'h3FFFFFFF, 4'b1000);
      run_one("ovf_rn",      5'd4, 1'b1, 11'd128,  25'd0,         3'b000, 1'b0, 2'b00, 1'b0, 32'hFF800000, 4'b1100);
      run_one("ovf_rz",      5'd5, 1'b1, 11'd128,  25'd0,         3'b000, 1'b0, 2'b01, 1'b0, 32'hFF7FFFFF, 4'b1100);
      run_one("tie_even",    5'd6, 1'b0, 11'd0,    25'h0000002,   3'b000, 1'b0, 2'b00, 1'b0, 32'h3F800000, 4'b1000);
      run_one("tie_odd",     5'd7, 1'b0, 11'd0,    25'h0000006,   3'b000, 1'b0, 2'b00, 1'b0, 32'h3F800002, 4'b1000);
      run_one("above_half",  5'd8, 1'b0, 11'd0,    25'h0000003,   3'b000, 1'b0, 2'b00, 1'b0, 32'h3F800001, 4'b1000);
      run_one("carry_ovf",   5'd9, 1'b0, 11'd127,  25'h1FFFFFF,   3'b000, 1'b0, 2'b00, 1'b0, 32'h7F800000, 4'b1100);
      run_one("max_rz",      5'd10, 1'b0, 11'd127, 25'h1FFFFFF,   3'b000, 1'b0, 2'b01, 1'b0, 32'h7F7FFFFF, 4'b1000);
      run_one("min_normal",  5'd11, 1'b0, -11'sd126, 25'd0,       3'b000, 1'b0, 2'b00, 1'b0, 32'h00800000, 4'b0000);
      run_one("tiny_dn1",    5'd12, 1'b0, -11'sd127, 25'd0,       3'b000, 1'b0, 2'b00, 1'b1, 32'h00000000, 4'b1010);
`ifdef FPU_RP_DENORM_EN
      run_one("tiny_dn0",    5'd13, 1'b0, -11'sd127, 25'd0,       3'b000, 1'b0, 2'b00, 1'b0, 32'h00400000, 4'b0000);
      run_one("denorm_carry",5'd14, 1'b0, -11'sd127, 25'h1FFFFFF, 3'b000, 1'b0, 2'b00, 1'b0, 32'h00800000, 4'b1010);
`else
      run_one("tiny_dn0",    5'd13, 1'b0, -11'sd127, 25'd0,       3'b000, 1'b0, 2'b00, 1'b0, 32'h00000000, 4'b1010);
      run_one("denorm_carry",5'd14, 1'b0, -11'sd127, 25'h1FFFFFF, 3'b000, 1'b0, 2'b00, 1'b0, 32'h00000000, 4'b1010);
`endif
      run_one("far_tiny",    5'd15, 1'b1, -11'sd200, 25'd0,       3'b000, 1'b0, 2'b00, 1'b0, 32'h80000000, 4'b1010);
      run_one("zero_neg",    5'd16, 1'b1, 11'd5,   25'h1234567,   3'b001, 1'b0, 2'b00, 1'b0, 32'h80000000, 4'b0000);
      run_one("inf_pos",     5'd17, 1'b0, 11'd5,   25'd0,         3'b010, 1'b0, 2'b00, 1'b0, 32'h7F800000, 4'b0000);
      run_one("nan_over_inf",5'd18, 1'b1, 11'd5,   25'd0,         3'b110, 1'b0, 2'b00, 1'b0, 32'h7FBFFFFF, 4'b0000);
      run_one("nan_invalid", 5'd19, 1'b0, 11'd0,   25'd0,         3'b100, 1'b1, 2'b00, 1'b0, 32'h7FBFFFFF, 4'b0001);
      run_one("inv_normal",  5'd20, 1'b0, 11'd0,   25'd0,         3'b000, 1'b1, 2'b00, 1'b0, 32'h3F800000, 4'b0001);

      // backpressure: three beats offered with o_ready low
      @(negedge clk);
      bus.o_ready = 1'b0;
      set_beat(5'd1, 1'b0, 11'd0, 25'd0, 3'b000, 1'b0, 2'b00, 1'b0);
      bus.i_valid = 1'b1;
      check("stall b1 i_ready", {31'd0, bus.i_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      set_beat(5'd2, 1'b0, 11'd1, 25'd0, 3'b000, 1'b0, 2'b00, 1'b0);
      check("stall b2 i_ready", {31'd0, bus.i_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      set_beat(5'd3, 1'b0, 11'd2, 25'd0, 3'b000, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("stall i_ready low", {31'd0, bus.i_ready}, 32'd0);
         check("stall o_tag", {27'd0, bus.o_tag}, 32'd1);
         check("stall o_result", bus.o_result, 32'h3F800000);
         @(negedge clk);
      end
      bus.o_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_valid = 1'b0;
      check("drain tag2", {27'd0, bus.o_tag}, 32'd2);
      check("drain res2", bus.o_result, 32'h40000000);
      @(negedge clk);
      check("drain valid3", {31'd0, bus.o_valid}, 32'd1);
      check("drain tag3", {27'd0, bus.o_tag}, 32'd3);
      check("drain res3", bus.o_result, 32'h40800000);
      @(negedge clk);
      check("drain empty", {31'd0, bus.o_valid}, 32'd0);

      // reset with two beats in flight
      set_beat(5'd7, 1'b0, 11'd0, 25'd0, 3'b100, 1'b1, 2'b00, 1'b0);
      bus.i_valid = 1'b1;
      @(negedge clk);
      set_beat(5'd8, 1'b0, 11'd0, 25'd0, 3'b000, 1'b0, 2'b00, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst o_valid", {31'd0, bus.o_valid}, 32'd0);
      check("midrst o_result", bus.o_result, 32'd0);
      check("midrst o_tag", {27'd0, bus.o_tag}, 32'd0);
      bus.i_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post-rst no stale", {31'd0, bus.o_valid}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
